// File: rtl/btb_pkg.sv
// Shared types, counter constants and PC split helpers for the set-associative BTB.
// Entry fields use fixed maximum widths so one struct serves every IDX_BITS/CTR_WIDTH (CTR_WIDTH <= 8).
package btb_pkg;

  localparam int CTR_MAXW      = 8;
  localparam int CTR_WIDTH_DEF = 2;

  typedef struct packed {
    logic                valid;
    logic [31:0]         tag;     // pc >> (IDX_BITS+2); upper bits stay zero
    logic [31:0]         target;
    logic [CTR_MAXW-1:0] ctr;
  } btb_entry_t;

  function automatic logic [CTR_MAXW-1:0] ctr_max(input int w);
    return CTR_MAXW'((1 << w) - 1);
  endfunction

  function automatic logic [CTR_MAXW-1:0] ctr_weak_taken(input int w);
    return CTR_MAXW'(1 << (w - 1));
  endfunction

  localparam logic [CTR_MAXW-1:0] CTR_MAX        = CTR_MAXW'((1 << CTR_WIDTH_DEF) - 1);
  localparam logic [CTR_MAXW-1:0] CTR_WEAK_TAKEN = CTR_MAXW'(1 << (CTR_WIDTH_DEF - 1));

  function automatic logic [31:0] btb_index(input logic [31:0] pc, input int idx_bits);
    return (pc >> 2) & ((32'd1 << idx_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] btb_tag(input logic [31:0] pc, input int idx_bits);
    return pc >> (idx_bits + 2);
  endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Lookup and training bus of the BTB.
// up_valid carries no ready: the BTB accepts an update on every cycle up_valid is high.
interface btb_assoc_if;
  logic [31:0] lk_pc;
  logic        lk_hit;
  logic        lk_taken;
  logic [31:0] lk_target;
  logic        up_valid;
  logic [31:0] up_pc;
  logic        up_taken;
  logic [31:0] up_target;
  logic        flush;

  modport master (
    output lk_pc, up_valid, up_pc, up_taken, up_target, flush,
    input  lk_hit, lk_taken, lk_target
  );

  modport slave (
    input  lk_pc, up_valid, up_pc, up_taken, up_target, flush,
    output lk_hit, lk_taken, lk_target
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up/down counter step: next = cur +/- 1, clamped to [0, 2**CTR_WIDTH-1].
module sat_counter #(
  parameter int CTR_WIDTH = 2
) (
  input  logic [CTR_WIDTH-1:0] cur,
  input  logic                 inc,
  input  logic                 dec,
  output logic [CTR_WIDTH-1:0] next
);
  localparam logic [CTR_WIDTH-1:0] MAX_VAL = '1;

  always_comb begin
    next = cur;
    if (inc && (cur != MAX_VAL)) begin
      next = cur + CTR_WIDTH'(1);
    end else if (dec && (cur != '0)) begin
      next = cur - CTR_WIDTH'(1);
    end
  end
endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB: combinational lookup on the fetch PC, single-cycle training port,
// invalid-first / round-robin allocation and whole-table flush.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int IDX_BITS  = 4,
  parameter int WAYS      = 2,
  parameter int CTR_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  btb_assoc_if.slave  bus
);
  localparam int SETS = 1 << IDX_BITS;
  localparam int VW   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CTR_MAXW-1:0] C_WEAK = ctr_weak_taken(CTR_WIDTH);

  btb_entry_t    tbl_q [SETS][WAYS];
  btb_entry_t    tbl_d [SETS][WAYS];
  logic [VW-1:0] vic_q [SETS];
  logic [VW-1:0] vic_d [SETS];

  // ---------------- lookup ----------------
  logic [IDX_BITS-1:0] lk_idx;
  logic [31:0]         lk_tag;
  logic                lk_hit;
  logic [VW-1:0]       lk_way;

  always_comb begin
    lk_idx = IDX_BITS'(btb_index(bus.lk_pc, IDX_BITS));
    lk_tag = btb_tag(bus.lk_pc, IDX_BITS);
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (tbl_q[lk_idx][w].valid && (tbl_q[lk_idx][w].tag == lk_tag)) begin
        lk_hit = 1'b1;
        lk_way = VW'(w);
      end
    end
  end

  // Counter never exceeds its max, so ">= weak-taken" is exactly "MSB set".
  assign bus.lk_hit    = lk_hit;
  assign bus.lk_taken  = lk_hit && (tbl_q[lk_idx][lk_way].ctr >= C_WEAK);
  assign bus.lk_target = bus.lk_taken ? tbl_q[lk_idx][lk_way].target : bus.lk_pc + 32'd4;

  // ---------------- update ----------------
  logic [IDX_BITS-1:0]  up_idx;
  logic [31:0]          up_tag;
  logic                 up_hit;
  logic [VW-1:0]        up_way;
  logic                 inv_found;
  logic [VW-1:0]        inv_way;
  logic [VW-1:0]        alloc_way;
  logic [CTR_WIDTH-1:0] ctr_next;

  always_comb begin
    up_idx    = IDX_BITS'(btb_index(bus.up_pc, IDX_BITS));
    up_tag    = btb_tag(bus.up_pc, IDX_BITS);
    up_hit    = 1'b0;
    up_way    = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (tbl_q[up_idx][w].valid && (tbl_q[up_idx][w].tag == up_tag)) begin
        up_hit = 1'b1;
        up_way = VW'(w);
      end
      if (!tbl_q[up_idx][w].valid && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = VW'(w);
      end
    end
    alloc_way = inv_found ? inv_way : vic_q[up_idx];
  end

  sat_counter #(.CTR_WIDTH(CTR_WIDTH)) u_ctr (
    .cur  (tbl_q[up_idx][up_way].ctr[CTR_WIDTH-1:0]),
    .inc  (bus.up_taken),
    .dec  (!bus.up_taken),
    .next (ctr_next)
  );

  always_comb begin
    tbl_d = tbl_q;
    vic_d = vic_q;
    if (bus.flush) begin
      // Only valid bits and pointers are cleared; stale payload is harmless once invalid.
      for (int s = 0; s < SETS; s++) begin
        vic_d[s] = '0;
        for (int w = 0; w < WAYS; w++) begin
          tbl_d[s][w].valid = 1'b0;
        end
      end
    end else if (bus.up_valid) begin
      if (up_hit) begin
        tbl_d[up_idx][up_way].ctr = CTR_MAXW'(ctr_next);
        if (bus.up_taken) begin
          tbl_d[up_idx][up_way].target = bus.up_target;
        end
      end else if (bus.up_taken) begin
        tbl_d[up_idx][alloc_way] = '{valid: 1'b1, tag: up_tag, target: bus.up_target, ctr: C_WEAK};
        if (!inv_found && (WAYS > 1)) begin
          vic_d[up_idx] = vic_q[up_idx] + VW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        vic_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tbl_q[s][w] <= '0;
        end
      end
    end else begin
      tbl_q <= tbl_d;
      vic_q <= vic_d;
    end
  end
endmodule
